uart_reg_master: RTL and testbench



---
 rtl/uart_reg_master_if.sv | 31 +++
 rtl/uart_reg_master.sv | 143 ++++++++++++++
 tb/tb_uart_reg_master.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_reg_master_if.sv
// Bundle of command, response and register-bank signals used by uart_reg_master.
// The master modport is the bus initiator; the slave modport is the host/bank side.
interface uart_reg_master_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_timeout;
    logic       w_e;
    logic [7:0] w_addr;
    logic [7:0] w_data;
    logic       r_e;
    logic [7:0] r_addr;
    logic [7:0] r_data;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready, r_data,
        output cmd_ready, rsp_valid, rsp_data, rsp_timeout,
        output w_e, w_addr, w_data, r_e, r_addr
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready, r_data,
        input  cmd_ready, rsp_valid, rsp_data, rsp_timeout,
        input  w_e, w_addr, w_data, r_e, r_addr
    );
endinterface

// File: rtl/uart_reg_master.sv
// Byte-command bus initiator for the UART register bank with polled TX/RX commands.
// Define UART_REG_MASTER_TIMEOUT_EN to bound polling to POLL_MAX reads of FSR.
module uart_reg_master #(
    parameter int POLL_MAX     = 1024,
    parameter int TX_FULL_BIT  = 0,
    parameter int RX_EMPTY_BIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    uart_reg_master_if.master bus
);
    localparam logic [7:0] ADDR_FSR = 8'd5;
    localparam logic [7:0] ADDR_TBR = 8'd6;
    localparam logic [7:0] ADDR_RBR = 8'd7;

    if (POLL_MAX < 2) begin : g_poll_max_check
        $error("POLL_MAX must be at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_READ, S_POLL, S_XFER, S_RESP
    } state_t;

    state_t     state_q, state_d;
    logic       rx_q, rx_d;         // low bit of the op: selects RX for polled commands
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;
    logic       timeout_q, timeout_d;
    logic       fsr_ok;

`ifdef UART_REG_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(POLL_MAX);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    assign fsr_ok = rx_q ? !bus.r_data[RX_EMPTY_BIT] : !bus.r_data[TX_FULL_BIT];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rx_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            timeout_q <= 1'b0;
`ifdef UART_REG_MASTER_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            rx_q      <= rx_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            timeout_q <= timeout_d;
`ifdef UART_REG_MASTER_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        rx_d      = rx_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        timeout_d = timeout_q;
`ifdef UART_REG_MASTER_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    rx_d      = bus.cmd_op[0];
                    addr_d    = {5'b0, bus.cmd_addr};
                    wdata_d   = bus.cmd_wdata;
                    rdata_d   = '0;
                    timeout_d = 1'b0;
`ifdef UART_REG_MASTER_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                    case (bus.cmd_op)
                        2'b00:   state_d = S_WRITE;
                        2'b01:   state_d = S_READ;
                        default: state_d = S_POLL;
                    endcase
                end
            end
            S_WRITE: state_d = S_RESP;
            S_READ: begin
                rdata_d = bus.r_data;
                state_d = S_RESP;
            end
            S_POLL: begin
                if (fsr_ok) begin
                    state_d = S_XFER;
                end else begin
`ifdef UART_REG_MASTER_TIMEOUT_EN
                    // cnt_q counts earlier failures, so this failure is number cnt_q+1
                    if (cnt_q == CNT_W'(POLL_MAX - 1)) begin
                        timeout_d = 1'b1;
                        state_d   = S_RESP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end
            end
            S_XFER: begin
                if (rx_q) rdata_d = bus.r_data;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode only registered state so cmd_*/rsp_ready never reach them.
    assign bus.cmd_ready   = (state_q == S_IDLE);
    assign bus.rsp_valid   = (state_q == S_RESP);
    assign bus.rsp_data    = (state_q == S_RESP) ? rdata_q : 8'd0;
`ifdef UART_REG_MASTER_TIMEOUT_EN
    assign bus.rsp_timeout = (state_q == S_RESP) && timeout_q;
`else
    assign bus.rsp_timeout = 1'b0;
`endif

    assign bus.w_e    = (state_q == S_WRITE) || (state_q == S_XFER && !rx_q);
    assign bus.w_addr = (state_q == S_WRITE) ? addr_q :
                        (state_q == S_XFER && !rx_q) ? ADDR_TBR : 8'd0;
    assign bus.w_data = bus.w_e ? wdata_q : 8'd0;

    // RBR pops on any cycle with r_addr=7, so 7 appears only in READ or RX XFER.
    assign bus.r_e    = (state_q == S_READ) || (state_q == S_POLL) ||
                        (state_q == S_XFER && rx_q);
    assign bus.r_addr = (state_q == S_READ) ? addr_q :
                        (state_q == S_POLL) ? ADDR_FSR :
                        (state_q == S_XFER && rx_q) ? ADDR_RBR : 8'd0;
endmodule

// File: tb/tb_uart_reg_master.sv
// Directed bench for uart_reg_master with a small behavioural register-bank model.
module tb_uart_reg_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    int         poll_count = 0;
    int         poll_base  = 0;
    int         tx_fail_n  = 0;
    logic       rx_empty   = 1'b1;
    logic [7:0] rbr_val    = 8'h00;
    logic [7:0] reg_val    = 8'h00;
    logic       tx_full_now;

    uart_reg_master_if bus_if ();

    uart_reg_master #(.POLL_MAX(8), .TX_FULL_BIT(0), .RX_EMPTY_BIT(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    always_comb begin
        tx_full_now = ((poll_count - poll_base) < tx_fail_n);
        case (bus_if.r_addr)
            8'd5:    bus_if.r_data = {6'b0, rx_empty, tx_full_now};
            8'd7:    bus_if.r_data = rbr_val;
            default: bus_if.r_data = reg_val;
        endcase
    end

    always @(posedge clk) begin
        if (bus_if.r_e && bus_if.r_addr == 8'd5) poll_count <= poll_count + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic accept(input logic [1:0] op, input logic [2:0] addr, input logic [7:0] wd);
        @(negedge clk);
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_op    = op;
        bus_if.cmd_addr  = addr;
        bus_if.cmd_wdata = wd;
        @(posedge clk);
        #1 bus_if.cmd_valid = 1'b0;
    endtask

    task automatic finish_rsp(input string name);
        bit seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (bus_if.rsp_valid) seen = 1;
        end
        total_cnt++;
        if (!seen) $display("FAIL %s_rsp_wait: rsp_valid never seen, required 1", name);
        else pass_cnt++;
        bus_if.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus_if.rsp_ready = 1'b0;
        $display("%s: response accepted", name);
    endtask

    task automatic test_reset(input string ctx);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total_cnt++; if (bus_if.cmd_ready !== 1'b1) $display("FAIL %s_cmd_ready: got %b want 1", ctx, bus_if.cmd_ready); else pass_cnt++;
        total_cnt++; if (bus_if.rsp_valid !== 1'b0) $display("FAIL %s_rsp_valid: got %b want 0", ctx, bus_if.rsp_valid); else pass_cnt++;
        total_cnt++; if ({bus_if.w_e, bus_if.r_e} !== 2'b00) $display("FAIL %s_strobes: got %b want 00", ctx, {bus_if.w_e, bus_if.r_e}); else pass_cnt++;
        total_cnt++; if ({bus_if.w_addr, bus_if.w_data, bus_if.r_addr} !== 24'h0) $display("FAIL %s_bus_zero: got %h want 000000", ctx, {bus_if.w_addr, bus_if.w_data, bus_if.r_addr}); else pass_cnt++;
        total_cnt++; if ({bus_if.rsp_data, bus_if.rsp_timeout} !== 9'h0) $display("FAIL %s_rsp_zero: got %h want 000", ctx, {bus_if.rsp_data, bus_if.rsp_timeout}); else pass_cnt++;
        rst = 1'b0;
        $display("%s: reset applied", ctx);
    endtask

    task automatic test_write();
        int wcnt = 0;
        accept(2'b00, 3'd1, 8'h5A);
        @(negedge clk);
        total_cnt++; if ({bus_if.w_e, bus_if.w_addr, bus_if.w_data} !== {1'b1, 8'd1, 8'h5A}) $display("FAIL write_c1: got w_e=%b addr=%h data=%h want 1/01/5a", bus_if.w_e, bus_if.w_addr, bus_if.w_data); else pass_cnt++;
        wcnt += int'(bus_if.w_e);
        for (int c = 2; c <= 3; c++) begin
            @(negedge clk);
            wcnt += int'(bus_if.w_e);
            if (c == 2) begin
                total_cnt++; if ({bus_if.rsp_valid, bus_if.rsp_data, bus_if.cmd_ready} !== {1'b1, 8'h00, 1'b0}) $display("FAIL write_rsp: got valid=%b data=%h ready=%b want 1/00/0", bus_if.rsp_valid, bus_if.rsp_data, bus_if.cmd_ready); else pass_cnt++;
            end
        end
        total_cnt++; if (wcnt !== 1) $display("FAIL write_strobe_count: got %0d want 1", wcnt); else pass_cnt++;
        finish_rsp("write addr 1 data 5a");
    endtask

    task automatic test_read();
        int r7 = 0;
        reg_val = 8'h2B;
        accept(2'b01, 3'd3, 8'h00);
        @(negedge clk);
        if (bus_if.r_addr == 8'd7) r7++;
        total_cnt++; if ({bus_if.r_e, bus_if.r_addr, bus_if.w_e} !== {1'b1, 8'd3, 1'b0}) $display("FAIL read_c1: got r_e=%b addr=%h w_e=%b want 1/03/0", bus_if.r_e, bus_if.r_addr, bus_if.w_e); else pass_cnt++;
        @(negedge clk);
        if (bus_if.r_addr == 8'd7) r7++;
        total_cnt++; if ({bus_if.rsp_valid, bus_if.rsp_data, bus_if.rsp_timeout, bus_if.r_e} !== {1'b1, 8'h2B, 1'b0, 1'b0}) $display("FAIL read_rsp: got valid=%b data=%h to=%b r_e=%b want 1/2b/0/0", bus_if.rsp_valid, bus_if.rsp_data, bus_if.rsp_timeout, bus_if.r_e); else pass_cnt++;
        total_cnt++; if (r7 !== 0) $display("FAIL read_no_rbr: got %0d cycles at addr 7 want 0", r7); else pass_cnt++;
        finish_rsp("read addr 3");
    endtask

    task automatic test_poll_tx();
        int reads5 = 0, writes = 0, good_w = 0, wcyc = 0, first = 0;
        poll_base = poll_count;
        tx_fail_n = 4;
        accept(2'b10, 3'd0, 8'hC3);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (bus_if.r_e && bus_if.r_addr == 8'd5) reads5++;
            if (bus_if.w_e) begin
                writes++;
                wcyc = c;
                if (bus_if.w_addr == 8'd6 && bus_if.w_data == 8'hC3) good_w++;
            end
            if (bus_if.rsp_valid && first == 0) first = c;
        end
        total_cnt++; if (reads5 !== 5) $display("FAIL ptx_polls: got %0d want 5", reads5); else pass_cnt++;
        total_cnt++; if (writes !== 1 || good_w !== 1) $display("FAIL ptx_write: got %0d writes %0d correct want 1/1", writes, good_w); else pass_cnt++;
        total_cnt++; if (wcyc !== 6) $display("FAIL ptx_write_cycle: got %0d want 6", wcyc); else pass_cnt++;
        total_cnt++; if (first !== 7) $display("FAIL ptx_rsp_cycle: got %0d want 7", first); else pass_cnt++;
        total_cnt++; if ({bus_if.rsp_data, bus_if.rsp_timeout} !== 9'h0) $display("FAIL ptx_rsp: got %h want 000", {bus_if.rsp_data, bus_if.rsp_timeout}); else pass_cnt++;
        tx_fail_n = 0;
        finish_rsp("polled tx data c3");
    endtask

    task automatic test_poll_rx();
        int r7 = 0, first = 0;
        rx_empty = 1'b0;
        rbr_val  = 8'h99;
        accept(2'b11, 3'd0, 8'h00);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (bus_if.r_addr == 8'd7) r7++;
            if (bus_if.rsp_valid && first == 0) first = c;
        end
        total_cnt++; if (r7 !== 1) $display("FAIL prx_rbr_cycles: got %0d want 1", r7); else pass_cnt++;
        total_cnt++; if (first !== 3) $display("FAIL prx_rsp_cycle: got %0d want 3", first); else pass_cnt++;
        total_cnt++; if (bus_if.rsp_data !== 8'h99) $display("FAIL prx_data: got %h want 99", bus_if.rsp_data); else pass_cnt++;
        rx_empty = 1'b1;
        finish_rsp("polled rx");
    endtask

    task automatic test_timeout();
        int polls = 0, writes = 0, first = 0, to_seen = 0;
        poll_base = poll_count;
        tx_fail_n = 1000000;
        accept(2'b10, 3'd0, 8'h77);
`ifdef UART_REG_MASTER_TIMEOUT_EN
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (bus_if.r_e && bus_if.r_addr == 8'd5) polls++;
            if (bus_if.w_e) writes++;
            if (bus_if.rsp_valid && first == 0) first = c;
        end
        total_cnt++; if (polls !== 8) $display("FAIL tmo_polls: got %0d want 8", polls); else pass_cnt++;
        total_cnt++; if (writes !== 0) $display("FAIL tmo_writes: got %0d want 0", writes); else pass_cnt++;
        total_cnt++; if (first !== 9) $display("FAIL tmo_rsp_cycle: got %0d want 9", first); else pass_cnt++;
        total_cnt++; if ({bus_if.rsp_timeout, bus_if.rsp_data} !== 9'h100) $display("FAIL tmo_flag: got to=%b data=%h want 1/00", bus_if.rsp_timeout, bus_if.rsp_data); else pass_cnt++;
        tx_fail_n = 0;
        finish_rsp("polled tx timeout");
`else
        for (int c = 1; c <= 110; c++) begin
            @(negedge clk);
            if (bus_if.r_e && bus_if.r_addr == 8'd5) polls++;
            if (bus_if.w_e) writes++;
            if (bus_if.rsp_valid) first++;
            if (bus_if.rsp_timeout) to_seen++;
        end
        total_cnt++; if (polls !== 110) $display("FAIL notmo_polls: got %0d want 110", polls); else pass_cnt++;
        total_cnt++; if (writes !== 0 || first !== 0) $display("FAIL notmo_idle: got %0d writes %0d rsp cycles want 0/0", writes, first); else pass_cnt++;
        total_cnt++; if (to_seen !== 0) $display("FAIL notmo_flag: got %0d timeout cycles want 0", to_seen); else pass_cnt++;
        $display("polled tx without timeout: still polling after 110 cycles");
        test_reset("abort_endless_poll");
        tx_fail_n = 0;
`endif
    endtask

    task automatic test_reset_mid_poll();
        poll_base = poll_count;
        tx_fail_n = 1000000;
        accept(2'b10, 3'd0, 8'h33);
        repeat (3) @(negedge clk);
        total_cnt++; if (bus_if.r_addr !== 8'd5) $display("FAIL mid_poll_state: got r_addr %h want 05", bus_if.r_addr); else pass_cnt++;
        test_reset("reset_in_poll");
        tx_fail_n = 0;
    endtask

    task automatic test_reset_in_resp();
        accept(2'b00, 3'd2, 8'hA5);
        repeat (2) @(negedge clk);
        total_cnt++; if (bus_if.rsp_valid !== 1'b1) $display("FAIL resp_hold_state: got rsp_valid %b want 1", bus_if.rsp_valid); else pass_cnt++;
        test_reset("reset_in_resp");
    endtask

    task automatic test_back_to_back();
        reg_val = 8'h44;
        bus_if.rsp_ready = 1'b1;
        accept(2'b00, 3'd2, 8'h11);
        @(negedge clk);
        total_cnt++; if ({bus_if.w_e, bus_if.w_addr, bus_if.w_data} !== {1'b1, 8'd2, 8'h11}) $display("FAIL b2b_write: got %b/%h/%h want 1/02/11", bus_if.w_e, bus_if.w_addr, bus_if.w_data); else pass_cnt++;
        @(negedge clk);
        @(negedge clk);
        total_cnt++; if ({bus_if.cmd_ready, bus_if.rsp_valid} !== 2'b10) $display("FAIL b2b_period: got ready/valid %b want 10", {bus_if.cmd_ready, bus_if.rsp_valid}); else pass_cnt++;
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_op    = 2'b01;
        bus_if.cmd_addr  = 3'd4;
        @(posedge clk);
        #1 bus_if.cmd_valid = 1'b0;
        @(negedge clk);
        total_cnt++; if ({bus_if.r_e, bus_if.r_addr} !== {1'b1, 8'd4}) $display("FAIL b2b_read: got %b/%h want 1/04", bus_if.r_e, bus_if.r_addr); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if ({bus_if.rsp_valid, bus_if.rsp_data} !== {1'b1, 8'h44}) $display("FAIL b2b_rsp: got %b/%h want 1/44", bus_if.rsp_valid, bus_if.rsp_data); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if ({bus_if.cmd_ready, bus_if.rsp_valid} !== 2'b10) $display("FAIL b2b_return: got ready/valid %b want 10", {bus_if.cmd_ready, bus_if.rsp_valid}); else pass_cnt++;
        bus_if.rsp_ready = 1'b0;
        $display("back-to-back write then read done");
    endtask

    initial begin
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_op    = 2'b00;
        bus_if.cmd_addr  = 3'd0;
        bus_if.cmd_wdata = 8'h00;
        bus_if.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        test_reset("reset");
        test_write();
        test_read();
        test_poll_tx();
        test_poll_rx();
        test_timeout();
        test_reset_mid_poll();
        test_reset_in_resp();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
